colorflow_gen: RTL

Parametrised test-pattern generator for the RGB LCD path. It takes the timing generator's sync/DE and pixel coordinates, and returns a registered pixel word plus syncs delayed to match. It succeeds the single-mode colour-flow display stage with four runtime-selectable patterns, generic channel widths, frame-synchronous mode switching, and an animated scroll offset. It sits between the LCD timing generator and the panel output pins.

---
 rtl/colorflow_pkg.sv | 25 ++
 rtl/colorflow_ramp.sv | 24 ++
 rtl/colorflow_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/colorflow_pkg.sv
// colorflow_pkg: shared types and constants for the colour-flow pattern generator.
package colorflow_pkg;

    // Runtime pattern selection, latched on the frame edge.
    typedef enum logic [1:0] {
        MODE_FLOW  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Number of ramp segments in one colour-flow cycle.
    localparam int unsigned NUM_SEGS = 6;

    // Colour-bar ordering as {R,G,B} on/off triples, bar 0 in the LSBs:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

    // Look up the {R,G,B} on/off triple for a 3-bit bar index.
    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        return BAR_RGB[int'(bar) * 3 +: 3];
    endfunction

endpackage

// File: rtl/colorflow_ramp.sv
// colorflow_ramp: scales the in-segment position down to one channel width
// and optionally mirrors it so the channel falls instead of rising.
module colorflow_ramp #(
    parameter int SEG_BITS = 6,
    parameter int C_W      = 5
) (
    input  logic [SEG_BITS-1:0] ramp_bits_i,
    input  logic                down_i,
    output logic [C_W-1:0]      value_o
);

    logic [C_W-1:0] ramp_s;

    // Keep the top C_W bits of the segment position; mirror about full scale when falling.
    always_comb begin
        ramp_s = C_W'(ramp_bits_i >> (SEG_BITS - C_W));
        if (down_i) begin
            value_o = {C_W{1'b1}} - ramp_s;
        end else begin
            value_o = ramp_s;
        end
    end

endmodule

// File: rtl/colorflow_gen.sv
// colorflow_gen: four-mode RGB test-pattern generator with a two-stage pipeline.
// Mode and scroll offset only change on the rising edge of in_vs so a frame
// is never torn; syncs travel alongside the pixel with the same latency.
module colorflow_gen
    import colorflow_pkg::*;
#(
    parameter int          X_W        = 11,
    parameter int          R_W        = 5,
    parameter int          G_W        = 6,
    parameter int          B_W        = 5,
    parameter int          SEG_BITS   = 6,
    parameter logic [15:0] SPEED      = 16'd1,
    parameter int          BAR_SHIFT  = 7,
    parameter int          GRID_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_hs,
    input  logic                   in_vs,
    input  logic                   in_de,
    input  logic [X_W-1:0]         x_in,
    input  logic [X_W-1:0]         y_in,
    input  logic [1:0]             mode,
    input  logic                   pause,
    input  logic [R_W+G_W+B_W-1:0] solid_color,
    output logic                   out_hs,
    output logic                   out_vs,
    output logic                   out_de,
    output logic [R_W+G_W+B_W-1:0] out_data,
    output logic [15:0]            frame_cnt
);

    localparam int PIX_W = R_W + G_W + B_W;

    // Frame-level state
    logic              vs_q;
    mode_e             mode_q;
    logic [15:0]       frame_cnt_q;
    logic [15:0]       offset_q;

    // Colour-flow register
    logic [R_W-1:0]    col_r_q, col_r_d;
    logic [G_W-1:0]    col_g_q, col_g_d;
    logic [B_W-1:0]    col_b_q, col_b_d;

    // Pipeline
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              hs_d1_q, vs_d1_q, de_d1_q;
    logic              out_hs_q, out_vs_q, out_de_q;
    logic [PIX_W-1:0]  out_data_q;

    // Combinational helpers
    logic              vs_rise_s;
    logic [15:0]       idx_s;
    logic [2:0]        seg_s;
    logic [2:0]        bar_rgb_s;
    logic [R_W-1:0]    ramp_r_s;
    logic [G_W-1:0]    ramp_g_s;
    logic [B_W-1:0]    ramp_b_s;

    assign vs_rise_s = in_vs & ~vs_q;
    assign idx_s     = 16'(x_in) + 16'(y_in) + offset_q;
    assign seg_s     = 3'((idx_s >> SEG_BITS) % 16'(NUM_SEGS));

    // Each channel falls in exactly one segment: R in 1, G in 3, B in 5.
    colorflow_ramp #(.SEG_BITS(SEG_BITS), .C_W(R_W)) u_ramp_r (
        .ramp_bits_i (idx_s[SEG_BITS-1:0]),
        .down_i      (seg_s == 3'd1),
        .value_o     (ramp_r_s)
    );

    colorflow_ramp #(.SEG_BITS(SEG_BITS), .C_W(G_W)) u_ramp_g (
        .ramp_bits_i (idx_s[SEG_BITS-1:0]),
        .down_i      (seg_s == 3'd3),
        .value_o     (ramp_g_s)
    );

    colorflow_ramp #(.SEG_BITS(SEG_BITS), .C_W(B_W)) u_ramp_b (
        .ramp_bits_i (idx_s[SEG_BITS-1:0]),
        .down_i      (seg_s == 3'd5),
        .value_o     (ramp_b_s)
    );

    // Advance the colour-flow register: only the channel owned by the current segment moves.
    always_comb begin
        col_r_d = col_r_q;
        col_g_d = col_g_q;
        col_b_d = col_b_q;
        if ((mode_q == MODE_FLOW) && in_de) begin
            case (seg_s)
                3'd0:    col_g_d = ramp_g_s;
                3'd1:    col_r_d = ramp_r_s;
                3'd2:    col_b_d = ramp_b_s;
                3'd3:    col_g_d = ramp_g_s;
                3'd4:    col_r_d = ramp_r_s;
                3'd5:    col_b_d = ramp_b_s;
                default: col_r_d = col_r_q;
            endcase
        end else begin
            col_r_d = col_r_q;
        end
    end

    // Select the pixel colour for the active pattern.
    always_comb begin
        bar_rgb_s = bar_rgb(x_in[BAR_SHIFT+2:BAR_SHIFT]);
        pix_d     = {PIX_W{1'b0}};
        case (mode_q)
            MODE_FLOW: pix_d = {col_r_d, col_g_d, col_b_d};
            MODE_BARS: pix_d = {{R_W{bar_rgb_s[2]}}, {G_W{bar_rgb_s[1]}}, {B_W{bar_rgb_s[0]}}};
            MODE_GRID: begin
                if ((x_in[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}}) ||
                    (y_in[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}})) begin
                    pix_d = {PIX_W{1'b1}};
                end else begin
                    pix_d = {PIX_W{1'b0}};
                end
            end
            MODE_SOLID: pix_d = solid_color;
            default:    pix_d = {PIX_W{1'b0}};
        endcase
    end

    // Frame-edge bookkeeping: latch mode, count frames, advance scroll offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            mode_q      <= MODE_FLOW;
            frame_cnt_q <= 16'd0;
            offset_q    <= 16'd0;
        end else begin
            vs_q <= in_vs;
            if (vs_rise_s) begin
                mode_q      <= mode_e'(mode);
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (!pause) begin
                    offset_q <= offset_q + SPEED;
                end
            end
        end
    end

    // Hold the colour-flow state between pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r_q <= {R_W{1'b0}};
            col_g_q <= {G_W{1'b0}};
            col_b_q <= {B_W{1'b0}};
        end else begin
            col_r_q <= col_r_d;
            col_g_q <= col_g_d;
            col_b_q <= col_b_d;
        end
    end

    // Two-stage output pipeline; blank the pixel outside the active area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q      <= {PIX_W{1'b0}};
            hs_d1_q    <= 1'b0;
            vs_d1_q    <= 1'b0;
            de_d1_q    <= 1'b0;
            out_hs_q   <= 1'b0;
            out_vs_q   <= 1'b0;
            out_de_q   <= 1'b0;
            out_data_q <= {PIX_W{1'b0}};
        end else begin
            pix_q      <= pix_d;
            hs_d1_q    <= in_hs;
            vs_d1_q    <= in_vs;
            de_d1_q    <= in_de;
            out_hs_q   <= hs_d1_q;
            out_vs_q   <= vs_d1_q;
            out_de_q   <= de_d1_q;
            out_data_q <= de_d1_q ? pix_q : {PIX_W{1'b0}};
        end
    end

    assign out_hs    = out_hs_q;
    assign out_vs    = out_vs_q;
    assign out_de    = out_de_q;
    assign out_data  = out_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule
